// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file and its busy-bit scoreboard.
// Provides the default data width and register count, the helper that turns a
// register count into an address width, and the index of the hardwired zero
// register.
package regfile_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;
    localparam int ZERO_REG      = 0;

    // Address width for a register count; a two-entry file still needs one bit.
    function automatic int addr_width(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for long-latency register results.
// A reserve marks a destination busy when a load issues; the load writeback
// clears it. A same-cycle reserve and clear of one register leaves it busy.
// busy_count is kept as an incremental popcount of the busy vector.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   set_en, set_rd    reserve request and its register
//   clr_en, clr_rd    clear request (load writeback) and its register
//   busy              current busy vector, bit 0 always 0
//   busy_count        number of busy registers, registered
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = DEFAULT_NREGS,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en,
    input  logic [AW-1:0]    set_rd,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_rd,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_count
);

    logic             set_hit;
    logic             clr_hit;
    logic             count_inc;
    logic             count_dec;
    logic [NREGS-1:0] busy_next;

    assign set_hit = set_en && (set_rd != AW'(ZERO_REG));
    assign clr_hit = clr_en && (clr_rd != AW'(ZERO_REG));

    // The set is applied after the clear so a same-register reserve wins.
    always_comb begin
        busy_next = busy;
        if (clr_hit) begin
            busy_next[clr_rd] = 1'b0;
        end
        if (set_hit) begin
            busy_next[set_rd] = 1'b1;
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    // Count only real transitions: reserving a busy register or clearing an
    // idle one changes nothing, and a clear overridden by a reserve is void.
    assign count_inc = set_hit && !busy[set_rd];
    assign count_dec = clr_hit && busy[clr_rd] && !(set_hit && (set_rd == clr_rd));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy <= busy_next;
            case ({count_inc, count_dec})
                2'b10:   busy_count <= busy_count + (AW+1)'(1);
                2'b01:   busy_count <= busy_count - (AW+1)'(1);
                default: busy_count <= busy_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two write ports, NREAD bypassed read ports, a
// debug read port and a busy-bit scoreboard for load results.
// Write port A (ALU writeback) has priority over port B (load writeback) for
// both the stored value and the bypass path; port B always clears busy.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   rs_addr            packed read addresses, port i at [i*AW +: AW]
//   rs_data, rs_busy   combinational read data / busy flag per port
//   wa_en/rd/data      write port A
//   wb_en/rd/data      write port B, also clears busy[wb_rd]
//   rsv_en, rsv_rd     mark a register busy from the next cycle
//   dbg_addr/data      unbypassed debug read
//   busy_count         number of busy registers
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN  = DEFAULT_XLEN,
    parameter  int NREGS = DEFAULT_NREGS,
    parameter  int NREAD = 2,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  wa_en,
    input  logic [AW-1:0]         wa_rd,
    input  logic [XLEN-1:0]       wa_data,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_rd,
    input  logic [AW-1:0]         dbg_addr,
    output logic [XLEN-1:0]       dbg_data,
    output logic [AW:0]           busy_count
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             wa_hit;
    logic             wb_hit;

    assign wa_hit = wa_en && (wa_rd != AW'(ZERO_REG));
    assign wb_hit = wb_en && (wb_rd != AW'(ZERO_REG));

    // Port A is written last so it overrides port B on a shared destination.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (wb_hit) begin
                regs[wb_rd] <= wb_data;
            end
            if (wa_hit) begin
                regs[wa_rd] <= wa_data;
            end
        end
    end

    // Per-port bypass; a port-B write in flight also masks the busy flag
    // because its data is the value being waited for.
    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [AW-1:0] addr;
        assign addr = rs_addr[p*AW +: AW];
        assign rs_data[p*XLEN +: XLEN] =
            (addr == AW'(ZERO_REG))       ? '0      :
            (wa_hit && (wa_rd == addr))   ? wa_data :
            (wb_hit && (wb_rd == addr))   ? wb_data :
                                            regs[addr];
        assign rs_busy[p] = busy[addr] && !(wb_hit && (wb_rd == addr));
    end

    assign dbg_data = regs[dbg_addr];

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_en     (rsv_en),
        .set_rd     (rsv_rd),
        .clr_en     (wb_en),
        .clr_rd     (wb_rd),
        .busy       (busy),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb with default parameters (32x32, 2 reads).
// Stimulus pushes hand-computed expectations into a queue; a monitor process
// pops and compares them against the DUT outputs at each sample strobe.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREAD = 2;

    // Output selectors
    localparam int K_RD0 = 0;
    localparam int K_RD1 = 1;
    localparam int K_BZ0 = 2;
    localparam int K_BZ1 = 3;
    localparam int K_DBG = 4;
    localparam int K_CNT = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic                  clock;
    logic                  reset;
    logic [NREAD*AW-1:0]   rs_addr;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD-1:0]      rs_busy;
    logic                  wa_en;
    logic [AW-1:0]         wa_rd;
    logic [XLEN-1:0]       wa_data;
    logic                  wb_en;
    logic [AW-1:0]         wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_rd;
    logic [AW-1:0]         dbg_addr;
    logic [XLEN-1:0]       dbg_data;
    logic [AW:0]           busy_count;

    exp_t sb_q[$];
    event check_ev;
    int   checks = 0;
    int   errors = 0;

    regfile_sb dut (
        .clock      (clock),
        .reset      (reset),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .rs_busy    (rs_busy),
        .wa_en      (wa_en),
        .wa_rd      (wa_rd),
        .wa_data    (wa_data),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rsv_en     (rsv_en),
        .rsv_rd     (rsv_rd),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .busy_count (busy_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] sampleOutput(input int kind);
        case (kind)
            K_RD0:   return rs_data[31:0];
            K_RD1:   return rs_data[63:32];
            K_BZ0:   return {31'b0, rs_busy[0]};
            K_BZ1:   return {31'b0, rs_busy[1]};
            K_DBG:   return dbg_data;
            K_CNT:   return {26'b0, busy_count};
            default: return 'x;
        endcase
    endfunction

    // Monitor: drain every queued expectation at each strobe.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(check_ev);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = sampleOutput(e.kind);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                             e.name, act, e.exp, $time);
                end
            end
        end
    end

    // Drives every input at once, then lets combinational outputs settle.
    task automatic applyStimulus(input logic a_en, input logic [4:0] a_rd,
                                 input logic [31:0] a_data,
                                 input logic b_en, input logic [4:0] b_rd,
                                 input logic [31:0] b_data,
                                 input logic r_en, input logic [4:0] r_rd,
                                 input logic [4:0] p0, input logic [4:0] p1,
                                 input logic [4:0] dbg);
        wa_en    = a_en;
        wa_rd    = a_rd;
        wa_data  = a_data;
        wb_en    = b_en;
        wb_rd    = b_rd;
        wb_data  = b_data;
        rsv_en   = r_en;
        rsv_rd   = r_rd;
        rs_addr  = {p1, p0};
        dbg_addr = dbg;
        #1;
    endtask

    task automatic quiet(input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] dbg);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, p0, p1, dbg);
    endtask

    task automatic checkOutput(input string name, input int kind, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // Strobe the monitor, then advance to the next falling edge.
    task automatic tick();
        -> check_ev;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        quiet(5'd0, 5'd0, 5'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;

        // Everything reads zero after reset
        for (int a = 0; a < 32; a++) begin
            quiet(5'(a), 5'(31 - a), 5'(a));
            checkOutput("rst_rd0", K_RD0, 32'h0);
            checkOutput("rst_rd1", K_RD1, 32'h0);
            checkOutput("rst_bz0", K_BZ0, 32'h0);
            checkOutput("rst_bz1", K_BZ1, 32'h0);
            checkOutput("rst_dbg", K_DBG, 32'h0);
            checkOutput("rst_cnt", K_CNT, 32'h0);
            tick();
        end

        // x0 ignores writes and never bypasses
        applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_bypass", K_RD0, 32'h0);
        tick();
        quiet(5'd0, 5'd0, 5'd0);
        checkOutput("x0_stored", K_RD0, 32'h0);
        checkOutput("x0_dbg", K_DBG, 32'h0);
        tick();

        // Port A bypass, then stored; debug port is not bypassed
        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd5);
        checkOutput("wa_bypass", K_RD0, 32'h12345678);
        checkOutput("dbg_nobypass", K_DBG, 32'h0);
        tick();
        quiet(5'd5, 5'd0, 5'd5);
        checkOutput("wa_stored", K_RD0, 32'h12345678);
        checkOutput("wa_dbg", K_DBG, 32'h12345678);
        tick();

        // Reserve x3, load writeback four cycles later
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd3, 5'd0);
        checkOutput("rsv3_c0_busy", K_BZ1, 32'h0);
        checkOutput("rsv3_c0_cnt", K_CNT, 32'h0);
        tick();
        quiet(5'd0, 5'd3, 5'd0);
        checkOutput("rsv3_c1_busy", K_BZ1, 32'h1);
        checkOutput("rsv3_c1_cnt", K_CNT, 32'h1);
        tick();
        quiet(5'd0, 5'd3, 5'd0);
        tick();
        quiet(5'd0, 5'd3, 5'd0);
        checkOutput("rsv3_c3_busy", K_BZ1, 32'h1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 5'd0, 5'd3, 5'd0);
        checkOutput("wb3_c4_busy", K_BZ1, 32'h0);
        checkOutput("wb3_c4_data", K_RD1, 32'h55);
        checkOutput("wb3_c4_cnt", K_CNT, 32'h1);
        tick();
        quiet(5'd0, 5'd3, 5'd0);
        checkOutput("wb3_c5_cnt", K_CNT, 32'h0);
        checkOutput("wb3_c5_busy", K_BZ1, 32'h0);
        checkOutput("wb3_c5_data", K_RD1, 32'h55);
        tick();

        // Both write ports to reserved x7: A wins data, B clears busy
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
        tick();
        quiet(5'd7, 5'd0, 5'd0);
        checkOutput("rsv7_busy", K_BZ0, 32'h1);
        checkOutput("rsv7_cnt", K_CNT, 32'h1);
        tick();
        applyStimulus(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h0000BBBB, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0);
        checkOutput("ab7_bypass", K_RD0, 32'hAAAA0000);
        checkOutput("ab7_busy", K_BZ0, 32'h0);
        tick();
        quiet(5'd7, 5'd0, 5'd7);
        checkOutput("ab7_stored", K_RD0, 32'hAAAA0000);
        checkOutput("ab7_dbg", K_DBG, 32'hAAAA0000);
        checkOutput("ab7_busy_after", K_BZ0, 32'h0);
        checkOutput("ab7_cnt", K_CNT, 32'h0);
        tick();

        // Reserve and clear x9 together: reserve wins
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
        checkOutput("rc9_busy_now", K_BZ0, 32'h0);
        checkOutput("rc9_data_now", K_RD0, 32'h99);
        checkOutput("rc9_cnt_now", K_CNT, 32'h1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd9, 5'd0, 5'd0);
        checkOutput("rc9_busy_next", K_BZ0, 32'h1);
        checkOutput("rc9_cnt_next", K_CNT, 32'h1);
        checkOutput("rc9_data_next", K_RD0, 32'h99);
        tick();
        // That cycle reserved x0; now re-reserve busy x9
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
        checkOutput("rsv0_busy", K_BZ1, 32'h0);
        checkOutput("rsv0_cnt", K_CNT, 32'h1);
        tick();
        // Reserve x10 while clearing x9: net count change zero
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9A, 1'b1, 5'd10, 5'd9, 5'd10, 5'd0);
        checkOutput("rsv9_again_cnt", K_CNT, 32'h1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 5'd9, 5'd10, 5'd0);
        checkOutput("swap_cnt", K_CNT, 32'h1);
        checkOutput("swap_busy9", K_BZ0, 32'h0);
        checkOutput("swap_data9", K_RD0, 32'h9A);
        tick();
        quiet(5'd0, 5'd10, 5'd10);
        checkOutput("wb10_cnt", K_CNT, 32'h0);
        checkOutput("wb10_dbg", K_DBG, 32'hA0);
        tick();

        // Port A does not clear busy
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd11, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd11, 5'd0, 5'd0);
        checkOutput("wa11_busy", K_BZ0, 32'h1);
        checkOutput("wa11_data", K_RD0, 32'h11);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h1111, 1'b0, 5'd0, 5'd11, 5'd0, 5'd0);
        checkOutput("wa11_busy_after", K_BZ0, 32'h0);
        checkOutput("wa11_cnt", K_CNT, 32'h1);
        tick();
        quiet(5'd11, 5'd0, 5'd0);
        checkOutput("wb11_cnt", K_CNT, 32'h0);
        tick();

        // Reserve and write x1..x4, then asynchronous reset between edges
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 5'(k), 32'(k), 1'b0, 5'd0, 32'h0, 1'b1, 5'(k), 5'd0, 5'd0, 5'd0);
            tick();
        end
        quiet(5'd1, 5'd4, 5'd2);
        checkOutput("pre_rst_cnt", K_CNT, 32'd4);
        checkOutput("pre_rst_rd1", K_RD0, 32'd1);
        checkOutput("pre_rst_rd4", K_RD1, 32'd4);
        checkOutput("pre_rst_bz1", K_BZ0, 32'h1);
        checkOutput("pre_rst_bz4", K_BZ1, 32'h1);
        checkOutput("pre_rst_dbg2", K_DBG, 32'd2);
        -> check_ev;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_rd0", K_RD0, 32'h0);
        checkOutput("async_rst_rd1", K_RD1, 32'h0);
        checkOutput("async_rst_bz0", K_BZ0, 32'h0);
        checkOutput("async_rst_bz1", K_BZ1, 32'h0);
        checkOutput("async_rst_dbg", K_DBG, 32'h0);
        checkOutput("async_rst_cnt", K_CNT, 32'h0);
        -> check_ev;
        #1;
        // Write and reserve attempted while reset is held are discarded
        wa_en   = 1'b1;
        wa_rd   = 5'd6;
        wa_data = 32'h66;
        rsv_en  = 1'b1;
        rsv_rd  = 5'd6;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        quiet(5'd1, 5'd2, 5'd6);
        checkOutput("post_rst_x1", K_RD0, 32'h0);
        checkOutput("post_rst_x2", K_RD1, 32'h0);
        checkOutput("post_rst_x6", K_DBG, 32'h0);
        checkOutput("post_rst_cnt", K_CNT, 32'h0);
        tick();
        quiet(5'd3, 5'd4, 5'd6);
        checkOutput("post_rst_x3", K_RD0, 32'h0);
        checkOutput("post_rst_x4", K_RD1, 32'h0);
        checkOutput("post_rst_bz3", K_BZ0, 32'h0);
        checkOutput("post_rst_x6b", K_DBG, 32'h0);
        -> check_ev;
        #1;

        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
